// File: rtl/exec_trace_buffer.sv
// Execution trace capture for the multicycle core: PC-triggered arming, DEPTH-entry
// circular store with stop-when-full or wrap policy, first-word-fall-through drain port.
module exec_trace_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wrap_mode,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              clear,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] adr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        rd_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [3:0]        out_rd,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] out_addr,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [1:0]        state
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_RUN    = 2'b10,
    ST_FROZEN = 2'b11
  } state_e;

  typedef struct packed {
    logic [1:0]        kind;
    logic [3:0]        rd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
  } entry_t;

  state_e           state_q;
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  entry_t new_entry;
  entry_t head;
  logic   ev;
  logic   push;
  logic   pop;
  logic   full;
  logic   wr_en;
  logic   overwrite;
  logic   freeze;
  logic   lost;

  // Event qualification and full-boundary decisions
  always_comb begin
    new_entry       = '0;
    new_entry.kind  = {mem_write, reg_write};
    new_entry.rd    = rd_idx;
    new_entry.pc    = pc;
    new_entry.instr = instr;
    new_entry.value = reg_write ? result : wdata;
    new_entry.addr  = mem_write ? adr : '0;

    ev        = reg_write | mem_write;
    push      = enable & ~clear & ev &
                ((state_q == ST_RUN) | ((state_q == ST_ARMED) & (pc == trig_pc)));
    full      = (count == CNT_W'(DEPTH));
    pop       = (count != '0) & out_ready & ~clear;
    wr_en     = push & (~full | pop | wrap_mode);
    overwrite = push & full & ~pop & wrap_mode;
    freeze    = push & full & ~pop & ~wrap_mode;
    // Events arriving while frozen are lost too
    lost      = (push & full & ~pop) |
                (enable & ~clear & ev & (state_q == ST_FROZEN));
  end

  // Storage has no reset; entries are only observed while count covers them
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop | overwrite) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_en & ~pop & ~full) count <= count + CNT_W'(1);
      else if (pop & ~wr_en)    count <= count - CNT_W'(1);
      if (lost) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Capture FSM: clear re-arms, enable low parks in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else if (clear) begin
      state_q <= !enable ? ST_IDLE : (trig_en ? ST_ARMED : ST_RUN);
    end else if (!enable) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_q <= trig_en ? ST_ARMED : ST_RUN;
        ST_ARMED:  if (freeze) state_q <= ST_FROZEN;
                   else if (push) state_q <= ST_RUN;
        ST_RUN:    if (freeze) state_q <= ST_FROZEN;
        ST_FROZEN: state_q <= ST_FROZEN;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign out_valid = (count != '0);
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_kind  = head.kind;
  assign out_rd    = head.rd;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_value = head.value;
  assign out_addr  = head.addr;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Scoreboarded bench for exec_trace_buffer (DEPTH=4): directed scenarios then random traffic,
// expected entries held in a queue model that the monitor drains on each handshake.
module tb_exec_trace_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0, wrap_mode = 1'b0, trig_en = 1'b0, clear = 1'b0;
  logic [DW-1:0] trig_pc = '0;
  logic          reg_write = 1'b0, mem_write = 1'b0;
  logic [DW-1:0] pc = '0, instr = '0, result = '0, adr = '0, wdata = '0;
  logic [3:0]    rd_idx = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [1:0]    out_kind;
  logic [3:0]    out_rd;
  logic [DW-1:0] out_pc, out_instr, out_value, out_addr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [1:0]    state;

  exec_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wrap_mode(wrap_mode), .trig_en(trig_en),
    .trig_pc(trig_pc), .clear(clear), .reg_write(reg_write), .mem_write(mem_write),
    .pc(pc), .instr(instr), .result(result), .adr(adr), .wdata(wdata), .rd_idx(rd_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_rd(out_rd),
    .out_pc(out_pc), .out_instr(out_instr), .out_value(out_value), .out_addr(out_addr),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  rd;
    logic [31:0] pc, instr, value, addr;
  } rec_t;

  rec_t exp_q[$];
  rec_t mr, nr;
  int   m_state = 0;
  int   m_drop = 0;
  bit   m_ovf = 1'b0;
  bit   cap;
  int   nxt;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as small ints, buffer as a queue of records
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_state = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
    end else if (clear) begin
      exp_q.delete();
      m_drop  = 0;
      m_ovf   = 1'b0;
      m_state = !enable ? 0 : (trig_en ? 1 : 2);
    end else if (!enable) begin
      m_state = 0;
    end else begin
      cap = (reg_write | mem_write) && (m_state == 2 || (m_state == 1 && pc == trig_pc));
      nxt = m_state;
      if (m_state == 0) nxt = trig_en ? 1 : 2;
      else if (m_state == 1 && cap) nxt = 2;
      if (m_state == 3 && (reg_write | mem_write)) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      if (cap) begin
        nr.kind  = {mem_write, reg_write};
        nr.rd    = rd_idx;
        nr.pc    = pc;
        nr.instr = instr;
        nr.value = reg_write ? result : wdata;
        nr.addr  = mem_write ? adr : 32'h0;
        if (exp_q.size() < DEPTH) exp_q.push_back(nr);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
          if (wrap_mode) begin
            void'(exp_q.pop_front());
            exp_q.push_back(nr);
          end else nxt = 3;
        end
      end
      m_state = nxt;
    end
  end

  // Monitor: compare status every cycle, pop and compare head on each handshake
  always @(negedge clk) begin
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("state", 64'(state), 64'(m_state));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (exp_q.size() == 0) chk("out_valid_empty", 64'(out_valid), 64'd0);
    else begin
      mr = exp_q[0];
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_kind", 64'(out_kind), 64'(mr.kind));
      chk("out_rd", 64'(out_rd), 64'(mr.rd));
      chk("out_pc", 64'(out_pc), 64'(mr.pc));
      chk("out_instr", 64'(out_instr), 64'(mr.instr));
      chk("out_value", 64'(out_value), 64'(mr.value));
      chk("out_addr", 64'(out_addr), 64'(mr.addr));
      if (out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic rw, input logic mw, input logic [31:0] p, input logic [31:0] r,
                    input logic [31:0] a, input logic [31:0] w);
    reg_write = rw; mem_write = mw; pc = p; result = r; adr = a; wdata = w;
    instr = $urandom; rd_idx = 4'($urandom_range(0, 15));
    cyc();
    reg_write = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  int rp;

  initial begin
    repeat (3) cyc();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    reset = 1'b1;
    cyc();

    // T1: immediate capture, three register writes, drain in order
    enable = 1'b1; trig_en = 1'b0; wrap_mode = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) ev(1'b1, 1'b0, 32'(i * 4), 32'(i + 1), $urandom, $urandom);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_head_pc", 64'(out_pc), 64'h0);
    chk("t1_kind", 64'(out_kind), 64'd1);
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    chk("t1_drained", 64'(count), 64'd0);

    // T2: trigger on pc 0x10
    trig_en = 1'b1; trig_pc = 32'h10;
    do_clear();
    chk("t2_armed", 64'(state), 64'd1);
    ev(1'b1, 1'b0, 32'h8, 32'h11, 0, 0);
    ev(1'b1, 1'b0, 32'hC, 32'h12, 0, 0);
    chk("t2_still_armed", 64'(state), 64'd1);
    ev(1'b1, 1'b0, 32'h10, 32'h13, 0, 0);
    ev(1'b1, 1'b0, 32'h14, 32'h14, 0, 0);
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_run", 64'(state), 64'd2);
    chk("t2_head_pc", 64'(out_pc), 64'h10);

    // T3: stop-when-full
    trig_en = 1'b0;
    do_clear();
    for (int i = 1; i <= 6; i++) ev(1'b1, 1'b0, 32'(i), 32'(i), 0, 0);
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_frozen", 64'(state), 64'd3);
    chk("t3_head_pc", 64'(out_pc), 64'd1);
    do_clear();
    chk("t3_clr_count", 64'(count), 64'd0);
    chk("t3_clr_state", 64'(state), 64'd2);

    // T4: wrap mode overwrites oldest
    wrap_mode = 1'b1;
    for (int i = 0; i < 6; i++) ev(1'b1, 1'b0, 32'(i), 32'(i), 0, 0);
    chk("t4_head_pc", 64'(out_pc), 64'd2);
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_drop", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;

    // T5: full with simultaneous push and pop
    wrap_mode = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) ev(1'b1, 1'b0, 32'(32'h100 + i * 4), $urandom, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ev(1'b1, 1'b0, 32'(32'h200 + i * 4), $urandom, 0, 0);
    out_ready = 1'b0;
    chk("t5_count", 64'(count), 64'd4);
    chk("t5_drop", 64'(drop_cnt), 64'd0);
    chk("t5_state", 64'(state), 64'd2);

    // T6: combined writeback and store, then reset mid-drain
    do_clear();
    ev(1'b1, 1'b1, 32'h30, 32'h20, 32'h40, 32'h55);
    chk("t6_kind", 64'(out_kind), 64'd3);
    chk("t6_value", 64'(out_value), 64'h20);
    chk("t6_addr", 64'(out_addr), 64'h40);
    ev(1'b0, 1'b1, 32'h34, 32'h21, 32'h44, 32'h66);
    ev(1'b1, 1'b0, 32'h38, 32'h22, 32'h48, 32'h77);
    out_ready = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_state", 64'(state), 64'd0);
    out_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;

    // Random traffic
    enable = 1'b1; trig_pc = 32'h10;
    rp = 2;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) rp = $urandom_range(0, 4);
      out_ready = ($urandom_range(0, 3) < rp);
      reg_write = ($urandom_range(0, 1) == 1);
      mem_write = ($urandom_range(0, 3) == 0);
      pc        = 32'($urandom_range(0, 7) * 4);
      instr     = $urandom;
      result    = $urandom;
      adr       = $urandom;
      wdata     = $urandom;
      rd_idx    = 4'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 79) == 0);
      enable    = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 99) == 0) wrap_mode = ~wrap_mode;
      if ($urandom_range(0, 49) == 0) trig_en = ~trig_en;
      cyc();
    end
    reg_write = 1'b0; mem_write = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (8) cyc();
    chk("final_empty", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
